// File: rtl/dmem_responder_if.sv
// MEM-stage data-memory bus between the CPU pipeline (master) and a responder (slave).
// Signal names follow the EX/MEM register outputs they are wired to.
interface dmem_responder_if;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        Stall_o;
    logic        Ack_o;
    logic        Err_o;

    modport master (
        output MemRead_i, MemWrite_i, addr_i, data_i,
        input  data_o, Stall_o, Ack_o, Err_o
    );

    modport slave (
        input  MemRead_i, MemWrite_i, addr_i, data_i,
        output data_o, Stall_o, Ack_o, Err_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle word data memory: latches one load/store, stalls the pipeline for
// LATENCY cycles, then performs the access and pulses Ack_o (with Err_o on faults).
module dmem_responder #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dmem_responder_if.slave  bus
);
    localparam int               IDX_W    = $clog2(DEPTH);
    localparam int               CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [31:0]      LIMIT    = 32'(4 * DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             rd_q, wr_q;
    logic [31:0]      addr_q, wdata_q;
    logic [31:0]      rdata_q;
    logic             ack_q, err_q;
    logic [31:0]      mem [DEPTH];

    logic             req, accept, finish, fault, stall;
    logic [IDX_W-1:0] idx;

    assign req   = bus.MemRead_i | bus.MemWrite_i;
    assign idx   = addr_q[IDX_W+1:2];
    assign fault = (rd_q & wr_q) | (addr_q[1:0] != 2'b00) | (addr_q >= LIMIT);

    // DONE never looks at the inputs, so a request still held there is not re-accepted.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept    = 1'b1;
                    stall     = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt == '0) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (rst_i) begin
            stall = 1'b0;
        end
    end

    // ---- control, result registers and storage ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            ack_q <= finish;
            err_q <= finish & fault;
            if (accept) begin
                rd_q <= bus.MemRead_i;
                wr_q <= bus.MemWrite_i;
                cnt  <= CNT_LOAD;
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (finish) begin
                if (fault) begin
                    if (rd_q) begin
                        rdata_q <= '0;
                    end
                end else if (rd_q) begin
                    rdata_q <= mem[idx];
                end else if (wr_q) begin
                    mem[idx] <= wdata_q;
                end
            end
        end
    end

    // ---- request payload capture ----
    always_ff @(posedge clk_i) begin
        if (accept) begin
            addr_q  <= bus.addr_i;
            wdata_q <= bus.data_i;
        end
    end

    assign bus.data_o  = rdata_q;
    assign bus.Ack_o   = ack_q;
    assign bus.Err_o   = err_q;
    assign bus.Stall_o = stall;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one LATENCY=3 and one LATENCY=1 instance checked against
// a word-array reference model plus hand-computed vector tables.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          sel = 0;
    logic        mr = 1'b0, mw = 1'b0;
    logic [31:0] ad = '0, dd = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_responder_if b3();
    dmem_responder_if b1();

    assign b3.MemRead_i  = mr & (sel == 0);
    assign b3.MemWrite_i = mw & (sel == 0);
    assign b3.addr_i     = ad;
    assign b3.data_i     = dd;
    assign b1.MemRead_i  = mr & (sel == 1);
    assign b1.MemWrite_i = mw & (sel == 1);
    assign b1.addr_i     = ad;
    assign b1.data_i     = dd;

    dmem_responder #(.DEPTH(32), .LATENCY(3)) dut  (.clk_i(clk), .rst_i(rst), .bus(b3.slave));
    dmem_responder #(.DEPTH(32), .LATENCY(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(b1.slave));

    logic        o_stall, o_ack, o_err;
    logic [31:0] o_data;
    assign o_stall = (sel == 1) ? b1.Stall_o : b3.Stall_o;
    assign o_ack   = (sel == 1) ? b1.Ack_o   : b3.Ack_o;
    assign o_err   = (sel == 1) ? b1.Err_o   : b3.Err_o;
    assign o_data  = (sel == 1) ? b1.data_o  : b3.data_o;

    // Reference model: one word array and last-read value per instance
    logic [31:0] mm   [2][32];
    logic [31:0] last [2];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t tbl [10];

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 2; s++) begin
            last[s] = '0;
            for (int i = 0; i < 32; i++) mm[s][i] = '0;
        end
    endtask

    task automatic model_access(input int s, input logic rd, input logic wr,
                                input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] exp_d, output logic exp_e);
        logic bad;
        bad = (rd && wr) || (a % 4 != 0) || (a >= 32'd128);
        if (rd) last[s] = bad ? 32'd0 : mm[s][a[6:2]];
        else if (wr && !bad) mm[s][a[6:2]] = d;
        exp_d = last[s];
        exp_e = bad;
    endtask

    // Starts just after a rising edge with the DUT idle; ends the same way after DONE.
    task automatic access(input int s, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_d, input logic exp_e);
        int lat;
        lat = (s == 1) ? 1 : 3;
        sel = s; mr = rd; mw = wr; ad = a; dd = d;
        for (int k = 0; k <= lat + 1; k++) begin
            @(negedge clk);
            chk_b("stall", o_stall, k <= lat);
            chk_b("ack", o_ack, k == lat + 1);
            if (k == lat + 1) begin
                chk_b("err", o_err, exp_e);
                chk_w("data", o_data, exp_d);
            end
            @(posedge clk); #1;
        end
        mr = 1'b0; mw = 1'b0;
    endtask

    task automatic run_model(input int s, input logic rd, input logic wr,
                             input logic [31:0] a, input logic [31:0] d);
        logic [31:0] ed;
        logic        ee;
        model_access(s, rd, wr, a, d, ed, ee);
        access(s, rd, wr, a, d, ed, ee);
    endtask

    initial begin
        logic [31:0] ed, a, d;
        logic        ee, rd, wr;
        int          r;

        tbl[0] = '{1'b0, 1'b1, 32'h08, 32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1] = '{1'b1, 1'b0, 32'h08, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 32'h06, 32'h0,        32'h0,        1'b1};
        tbl[3] = '{1'b0, 1'b1, 32'h00, 32'hA5A5A5A5, 32'h0,        1'b0};
        tbl[4] = '{1'b0, 1'b1, 32'h80, 32'h11111111, 32'h0,        1'b1};
        tbl[5] = '{1'b1, 1'b0, 32'h00, 32'h0,        32'hA5A5A5A5, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 32'h08, 32'hCAFEF00D, 32'h0,        1'b1};
        tbl[7] = '{1'b1, 1'b0, 32'h08, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 32'h7C, 32'h13572468, 32'hDEADBEEF, 1'b0};
        tbl[9] = '{1'b1, 1'b0, 32'h7C, 32'h0,        32'h13572468, 1'b0};

        model_clear();

        // Reset held with a load request pending
        sel = 0; mr = 1'b1; ad = 32'h0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk_b("reset_stall", o_stall, 1'b0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk_b("reset_stall", o_stall, 1'b0);
        chk_b("reset_ack", o_ack, 1'b0);
        chk_b("reset_err", o_err, 1'b0);
        chk_w("reset_data", o_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_access(0, 1'b1, 1'b0, 32'h0, 32'h0, ed, ee);
        access(0, 1'b1, 1'b0, 32'h0, 32'h0, ed, ee);

        // Directed vector table on the LATENCY=3 instance
        for (int i = 0; i < 10; i++) begin
            model_access(0, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data, ed, ee);
            access(0, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data,
                   tbl[i].exp_data, tbl[i].exp_err);
        end

        // Load held high across several accesses: one ack every LATENCY+2 cycles
        sel = 0; mr = 1'b1; mw = 1'b0; ad = 32'h08;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            chk_b("hold_ack", o_ack, (k % 5) == 4);
            chk_b("hold_stall", o_stall, (k % 5) != 4);
            if ((k % 5) == 4) chk_w("hold_data", o_data, 32'hDEADBEEF);
            @(posedge clk); #1;
        end
        mr = 1'b0;

        // Reset in the second BUSY cycle of a store aborts it
        sel = 0; mw = 1'b1; ad = 32'h04; dd = 32'h12345678;
        @(negedge clk);
        chk_b("abort_stall", o_stall, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; mw = 1'b0;
        @(negedge clk);
        chk_b("abort_rst_stall", o_stall, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk_b("abort_no_ack", o_ack, 1'b0);
            @(posedge clk); #1;
        end
        run_model(0, 1'b1, 1'b0, 32'h04, 32'h0);
        chk_w("abort_model", last[0], 32'h0);

        // Randomized traffic against the model, both instances
        for (int i = 0; i < 50; i++) begin
            r  = $urandom_range(0, 9);
            rd = 1'(($urandom & 1) == 1);
            wr = !rd;
            d  = $urandom;
            if (r < 7)       a = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
            else if (r == 7) a = {25'd0, 5'($urandom_range(0, 31)), 2'($urandom_range(1, 3))};
            else if (r == 8) a = {20'd0, 10'($urandom_range(32, 1023)), 2'b00};
            else begin
                a = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
                rd = 1'b1; wr = 1'b1;
            end
            run_model((i < 35) ? 0 : 1, rd, wr, a, d);
        end

        // LATENCY=1: stall two cycles, result on the third
        run_model(1, 1'b0, 1'b1, 32'h10, 32'h0BADF00D);
        access(1, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0BADF00D, 1'b0);
        last[1] = 32'h0BADF00D;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder serving the pipelined CPU's MEM stage. Accepts one load or store from the EX/MEM pipeline register outputs and holds the pipeline with `Stall_o` for a fixed, parameterised latency. It then performs the word access and signals completion with `Ack_o`. The block is the responder end of the MEM-stage memory interface and replaces the single-cycle data memory when memory latency must be modelled.

## Interface
- `DEPTH`, 32: number of 32-bit words; power of two, at least 2.
- `LATENCY`, 3: access latency in cycles; at least 1.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `MemRead_i` in 1: load request (EX/MEM MemRead).
- `MemWrite_i` in 1: store request (EX/MEM MemWrite).
- `addr_i` in 32: byte address (EX/MEM ALU result).
- `data_i` in 32: store data (EX/MEM RS2 data).
- `data_o` out 32: load data, registered.
- `Stall_o` out 1: pipeline hold request to PC, IF/ID, ID/EX, EX/MEM and MEM/WB write enables.
- `Ack_o` out 1: one-cycle completion pulse, registered.
- `Err_o` out 1: error flag; pulses together with `Ack_o` for a faulting request.

## Operation
- **States:**
  - IDLE: waiting for a request.
  - BUSY: latency countdown.
  - DONE: completion cycle; the pipeline releases here.
- **IDLE:**
  - A request is `MemRead_i | MemWrite_i`.
  - On a request, latch the operation, `addr_i` and `data_i`, load the counter with `LATENCY-1`, and go to BUSY.
  - With no request, stay in IDLE.
- **BUSY:**
  - If the counter is 0, perform the access, set `Ack_o`=1 and go to DONE.
  - Otherwise decrement the counter.
  - Inputs are ignored in BUSY; only the latched copies are used.
- **DONE:**
  - `Ack_o`=1 for this cycle only.
  - Go to IDLE unconditionally.
  - A request still present on the inputs in this cycle is the same, already-served instruction and must not be re-accepted.
- **Stall_o:** combinational, `(IDLE & request) | BUSY`. It is forced to 0 while `rst_i`=1.
- **Address rules:**
  - Word index is `addr[log2(DEPTH)+1:2]`.
  - Misaligned means `addr[1:0]` != 0.
  - Out of range means `addr >= 4*DEPTH`.
- **Error cases:** a misaligned address, an out-of-range address, or `MemRead_i` and `MemWrite_i` both 1.
  - The request follows the normal handshake timing.
  - Memory is not written.
  - If the request was a read, `data_o` is set to 0.
  - `Err_o`=1 together with `Ack_o`.
- **Read:** `data_o` is set to `mem[index]` on entry to DONE. `data_o` holds its value until the next read completes; writes never change `data_o`.
- **Write:** `mem[index]` is set to the latched data on entry to DONE.

## Timing
- **Reset values:**
  - Registers: state IDLE, counter 0, `data_o`=0, `Ack_o`=0, `Err_o`=0.
  - All `DEPTH` memory words are 0.
  - `Stall_o`=0.
- **Latency:** with a request first seen in IDLE at cycle T:
  - `Stall_o`=1 in cycles T..T+LATENCY, i.e. LATENCY+1 cycles.
  - DONE, `Ack_o` and valid `data_o` occur in cycle T+LATENCY+1, with `Stall_o`=0.
  - The pipeline advances at the end of cycle T+LATENCY+1.
- **Back-to-back requests:** the earliest next acceptance is cycle T+LATENCY+2, in IDLE. Throughput is one access per LATENCY+2 cycles.
- **LATENCY=1:** stall in T and T+1, DONE in T+2.
- **Ordering:** a read following a write to the same word returns the written value, because the write commits before the next IDLE.
- **Reset during BUSY or DONE:**
  - The next state is IDLE and an in-flight write is discarded with memory cleared to 0.
  - `Ack_o`, `Err_o` and `data_o` go to 0.
  - No `Ack_o` is emitted for the aborted request.
- **Request held through reset release:** a request present on the first cycle after `rst_i` falls is accepted normally.

## Test plan
- **Reset:** hold `rst_i` for 2 cycles with `MemRead_i`=1 -> `Stall_o`=0 throughout; after release, `data_o`=0, `Ack_o`=0, `Err_o`=0, and a read of address 0x0 returns 0.
- **Store then load, LATENCY=3:** store 0xDEADBEEF to 0x8, then load 0x8 -> `Stall_o` high for exactly 4 cycles per access; `Ack_o` pulses 1 cycle per access; `data_o`=0xDEADBEEF on the load's DONE; `data_o` unchanged by the store.
- **DONE re-accept check:** hold `MemRead_i`=1 continuously -> `Ack_o` pulses spaced exactly 5 cycles apart; never 2 acks within 5 cycles.
- **Errors:**
  - Load 0x6 -> `Err_o`=1 with `Ack_o`, `data_o`=0.
  - Store to 0x80 with DEPTH=32 -> `Err_o`=1 and memory unchanged on readback.
  - `MemRead_i`=`MemWrite_i`=1 -> `Err_o`=1 and no write.
- **Reset mid-access:** assert `rst_i` in the second BUSY cycle of a store of 0x12345678 to 0x4 -> no `Ack_o`; a subsequent load of 0x4 returns 0.
- **LATENCY=1 parameterisation:** a load of a pre-stored word -> `Stall_o` high for 2 cycles; `Ack_o` and data arrive on the 3rd cycle.
